// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_pkg
//  Purpose  : Shared types and constants for the code/data memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int DEFAULT_DEPTH = 4;
    localparam int ADDR_W        = 32;
    localparam int DATA_W        = 32;

    // Which upstream master a read belongs to; stored as the route tag.
    typedef enum logic {
        SRC_CODE = 1'b0,
        SRC_DATA = 1'b1
    } src_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : AXI4-Lite channel bundle with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_route_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_route_fifo
//  Purpose  : DEPTH-entry FIFO of source tags recording read issue order.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter_route_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  wire  clk,
    input  wire  resetn,
    input  wire  push_i,
    input  src_t push_tag_i,
    input  wire  pop_i,
    output logic full_o,
    output logic empty_o,
    output src_t head_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    src_t             slots_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign head_o  = slots_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next pointer/count values; pointers wrap at DEPTH, not at a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy state, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage; contents are only meaningful while counted, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            slots_q[wr_ptr_q] <= push_tag_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Round-robin read arbiter sharing one AXI4-Lite port between
//             instruction fetch (read-only) and load/store masters.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  wire            clk,
    input  wire            resetn,
    mem_arbiter_if.slave   code,
    mem_arbiter_if.slave   data,
    mem_arbiter_if.master  mem
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ISSUE = 1'b1;

    logic [0:0]        state_q, state_d;
    src_t              last_q, last_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [2:0]        arprot_q, arprot_d;

    src_t grant;
    logic ar_take;
    logic fifo_full, fifo_empty;
    src_t fifo_head;
    logic r_pop;

    // Pick a requester; acceptance is blocked in reset, in ISSUE and when full.
    always_comb begin
        grant   = SRC_CODE;
        ar_take = 1'b0;
        if (resetn && (state_q == ST_IDLE) && !fifo_full) begin
            if (code.arvalid && data.arvalid) begin
                grant   = (last_q == SRC_CODE) ? SRC_DATA : SRC_CODE;
                ar_take = 1'b1;
            end else if (code.arvalid) begin
                grant   = SRC_CODE;
                ar_take = 1'b1;
            end else if (data.arvalid) begin
                grant   = SRC_DATA;
                ar_take = 1'b1;
            end
        end
    end

    assign code.arready = ar_take && (grant == SRC_CODE);
    assign data.arready = ar_take && (grant == SRC_DATA);

    // AR FSM: capture the granted request, then hold it on mem until accepted.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        araddr_d = araddr_q;
        arprot_d = arprot_q;
        case (state_q)
            ST_IDLE: begin
                if (ar_take) begin
                    state_d  = ST_ISSUE;
                    last_d   = grant;
                    araddr_d = (grant == SRC_DATA) ? data.araddr : code.araddr;
                    arprot_d = (grant == SRC_DATA) ? data.arprot : code.arprot;
                end
            end
            ST_ISSUE: begin
                if (mem.arready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // AR register and round-robin history; last starts at CODE so data wins first tie.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            last_q   <= SRC_CODE;
            araddr_q <= '0;
            arprot_q <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            araddr_q <= araddr_d;
            arprot_q <= arprot_d;
        end
    end

    assign mem.arvalid = (state_q == ST_ISSUE);
    assign mem.araddr  = araddr_q;
    assign mem.arprot  = arprot_q;

    mem_arbiter_route_fifo #(
        .DEPTH (DEPTH)
    ) u_route_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .push_i     (ar_take),
        .push_tag_i (grant),
        .pop_i      (r_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

    // R beats go to the master at the FIFO head; nothing is accepted when empty.
    assign code.rvalid = !fifo_empty && (fifo_head == SRC_CODE) && mem.rvalid;
    assign data.rvalid = !fifo_empty && (fifo_head == SRC_DATA) && mem.rvalid;
    assign code.rdata  = mem.rdata;
    assign code.rresp  = mem.rresp;
    assign data.rdata  = mem.rdata;
    assign data.rresp  = mem.rresp;
    assign mem.rready  = !fifo_empty &&
                         ((fifo_head == SRC_CODE) ? code.rready : data.rready);
    assign r_pop       = mem.rvalid && mem.rready;

    // Data-side writes pass straight through.
    assign mem.awaddr   = data.awaddr;
    assign mem.awprot   = data.awprot;
    assign mem.awvalid  = data.awvalid;
    assign data.awready = mem.awready;
    assign mem.wdata    = data.wdata;
    assign mem.wstrb    = data.wstrb;
    assign mem.wvalid   = data.wvalid;
    assign data.wready  = mem.wready;
    assign data.bresp   = mem.bresp;
    assign data.bvalid  = mem.bvalid;
    assign mem.bready   = data.bready;

    // Fetch never writes: its write channels are held idle.
    assign code.awready = 1'b0;
    assign code.wready  = 1'b0;
    assign code.bvalid  = 1'b0;
    assign code.bresp   = RESP_OKAY;

endmodule
`default_nettype wire
